// File: rtl/ice_resp_arbiter.sv
// Round-robin response arbiter: serves one channel's receive FIFO at a time and streams it to the UART
// as tag + ASCII hex + line end. Define ICE_RESP_CRLF_EN to end each packet with CR LF instead of LF.
module ice_resp_arbiter #(
   parameter int                 NCH     = 2,
   parameter int                 CW      = 3,
   parameter logic [NCH*8-1:0]   CH_TAGS = 16'h6362,
   parameter int                 MAX_LEN = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NCH-1:0]     ch_req,
   input  logic [NCH*8-1:0]   ch_data,
   input  logic [NCH-1:0]     ch_valid,
   output logic [NCH-1:0]     ch_pop,
   output logic [7:0]         uart_tx_data,
   output logic               uart_tx_latch,
   input  logic               uart_tx_empty,
   output logic               busy,
   output logic [CW-1:0]      grant_ch,
   output logic               truncated
);

   // state | meaning
   // IDLE  | waiting for a pending request; arbitrates round-robin from rr_ptr
   // HDR   | sending the granted channel's tag character
   // DATA  | sending FIFO bytes as two hex characters each, up to MAX_LEN bytes
   // EOL   | sending line end (CR when CRLF is enabled, else LF)
   // EOL2  | sending LF after CR (CRLF builds only)
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_EOL, S_EOL2} state_t;

   localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

   state_t           state_q;
   logic [NCH-1:0]   pending_q, pending_d;
   logic [CW-1:0]    rr_ptr_q;
   logic [CW-1:0]    grant_ch_q;
   logic             nib_q;
   logic [7:0]       len_q;
   logic             prev_latch_q;

   logic [7:0]       head_byte;
   logic             head_valid;
   logic [7:0]       tag_byte;
   logic             found;
   logic [CW-1:0]    pick;
   logic [NCH-1:0]   grant_clr;
   logic             can_load;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   always_comb begin
      head_byte  = 8'h00;
      head_valid = 1'b0;
      tag_byte   = 8'h00;
      for (int i = 0; i < NCH; i++) begin
         if (grant_ch_q == CW'(i)) begin
            head_byte  = ch_data[8*i +: 8];
            head_valid = ch_valid[i];
            tag_byte   = CH_TAGS[8*i +: 8];
         end
      end
   end

   // Closest pending channel at or after rr_ptr, measured as circular distance.
   always_comb begin
      int d;
      int best_d;
      found  = 1'b0;
      pick   = '0;
      d      = 0;
      best_d = NCH;
      for (int i = 0; i < NCH; i++) begin
         d = i - int'(rr_ptr_q);
         if (d < 0) d = d + NCH;
         if (pending_q[i] && (d < best_d)) begin
            best_d = d;
            pick   = CW'(i);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      grant_clr = '0;
      if ((state_q == S_IDLE) && found) grant_clr = NCH'(1) << pick;
      pending_d = (pending_q & ~grant_clr) | ch_req;
   end

   assign can_load = uart_tx_empty && !prev_latch_q;

   always_comb begin
      uart_tx_latch = 1'b0;
      uart_tx_data  = 8'h00;
      ch_pop        = '0;
      truncated     = 1'b0;
      case (state_q)
         S_HDR: begin
            if (can_load) begin
               uart_tx_latch = 1'b1;
               uart_tx_data  = tag_byte;
            end
         end
         S_DATA: begin
            if (head_valid) begin
               if (len_q == LEN_MAX) begin
                  truncated = 1'b1;
               end else if (can_load) begin
                  uart_tx_latch = 1'b1;
                  uart_tx_data  = nib_q ? hex_char(head_byte[3:0]) : hex_char(head_byte[7:4]);
                  if (nib_q) ch_pop = NCH'(1) << grant_ch_q;
               end
            end
         end
         S_EOL: begin
            if (can_load) begin
               uart_tx_latch = 1'b1;
`ifdef ICE_RESP_CRLF_EN
               uart_tx_data  = 8'h0d;
`else
               uart_tx_data  = 8'h0a;
`endif
            end
         end
         S_EOL2: begin
            if (can_load) begin
               uart_tx_latch = 1'b1;
               uart_tx_data  = 8'h0a;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         rr_ptr_q     <= '0;
         grant_ch_q   <= '0;
         nib_q        <= 1'b0;
         len_q        <= 8'h00;
         prev_latch_q <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         prev_latch_q <= uart_tx_latch;
         case (state_q)
            S_IDLE: begin
               if (found) begin
                  grant_ch_q <= pick;
                  rr_ptr_q   <= (pick == CW'(NCH-1)) ? '0 : pick + CW'(1);
                  len_q      <= 8'h00;
                  nib_q      <= 1'b0;
                  state_q    <= S_HDR;
               end
            end
            S_HDR: begin
               if (uart_tx_latch) state_q <= S_DATA;
            end
            S_DATA: begin
               if (!head_valid || (len_q == LEN_MAX)) begin
                  state_q <= S_EOL;
               end else if (uart_tx_latch) begin
                  nib_q <= ~nib_q;
                  if (nib_q) len_q <= len_q + 8'h01;
               end
            end
            S_EOL: begin
`ifdef ICE_RESP_CRLF_EN
               if (uart_tx_latch) state_q <= S_EOL2;
`else
               if (uart_tx_latch) state_q <= S_IDLE;
`endif
            end
            S_EOL2: begin
               if (uart_tx_latch) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign grant_ch = grant_ch_q;

endmodule

// File: tb/tb_ice_resp_arbiter.sv
// Self-checking bench for ice_resp_arbiter: directed scenarios plus randomized rounds scored against
// a packet-level model (FIFO copies, round-robin order, expected character stream).
module tb_ice_resp_arbiter;

   localparam int NCH     = 3;
   localparam int CW      = 2;
   localparam int MAX_LEN = 2;
   localparam logic [NCH*8-1:0] TAGS = {8'h61, 8'h63, 8'h62};

   logic               clk = 1'b0;
   logic               reset;
   logic [NCH-1:0]     ch_req;
   logic [NCH*8-1:0]   ch_data;
   logic [NCH-1:0]     ch_valid;
   logic [NCH-1:0]     ch_pop;
   logic [7:0]         uart_tx_data;
   logic               uart_tx_latch;
   logic               uart_tx_empty;
   logic               busy;
   logic [CW-1:0]      grant_ch;
   logic               truncated;

   ice_resp_arbiter #(.NCH(NCH), .CW(CW), .CH_TAGS(TAGS), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_data(ch_data), .ch_valid(ch_valid),
      .ch_pop(ch_pop), .uart_tx_data(uart_tx_data), .uart_tx_latch(uart_tx_latch),
      .uart_tx_empty(uart_tx_empty), .busy(busy), .grant_ch(grant_ch), .truncated(truncated)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [7:0] fifo [NCH][$];
   logic [7:0] mq   [NCH][$];
   logic [7:0] exp_q[$];
   byte unsigned tag_tab [NCH] = '{8'h62, 8'h63, 8'h61};
   string hexs = "0123456789ABCDEF";

   int  m_rr = 0, m_last = 0, exp_trunc = 0, exp_pops = 0;
   int  n_pops = 0, n_trunc = 0, n_lat = 0;
   logic busy_s = 1'b0, prev_lat = 1'b0, rand_empty = 1'b0;

   task automatic drive_fifo();
      for (int i = 0; i < NCH; i++) begin
         ch_valid[i] = (fifo[i].size() != 0);
         ch_data[8*i +: 8] = (fifo[i].size() != 0) ? fifo[i][0] : 8'($urandom);
      end
   endtask

   task automatic push(input int c, input logic [7:0] b);
      fifo[c].push_back(b);
      mq[c].push_back(b);
      drive_fifo();
   endtask

   task automatic push_eol();
`ifdef ICE_RESP_CRLF_EN
      exp_q.push_back(8'h0d);
`endif
      exp_q.push_back(8'h0a);
   endtask

   task automatic serve_model(input int c);
      int n;
      logic [7:0] b;
      exp_q.push_back(tag_tab[c]);
      n = (mq[c].size() > MAX_LEN) ? MAX_LEN : mq[c].size();
      if (mq[c].size() > MAX_LEN) exp_trunc++;
      for (int k = 0; k < n; k++) begin
         b = mq[c].pop_front();
         exp_q.push_back(hexs[b[7:4]]);
         exp_q.push_back(hexs[b[3:0]]);
      end
      exp_pops += n;
      push_eol();
   endtask

   // All channels in mask become pending together; they are served in circular order from m_rr.
   task automatic model_grant(input logic [NCH-1:0] mask);
      int c;
      for (int k = 0; k < NCH; k++) begin
         c = (m_rr + k) % NCH;
         if (mask[c]) begin
            serve_model(c);
            m_last = c;
         end
      end
      if (mask != 0) m_rr = (m_last + 1) % NCH;
   endtask

   task automatic tick();
      logic lat;
      logic [7:0] dat, e;
      logic [NCH-1:0] pop;
      @(negedge clk);
      lat = uart_tx_latch;
      dat = uart_tx_data;
      pop = ch_pop;
      busy_s = busy;
      if (lat) begin
         chk("unexpected_char", ((exp_q.size() != 0) === 1'b1), (exp_q.size() != 0), 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("char", (dat === e), dat, e);
         end
         chk("load_spacing", (prev_lat === 1'b0), prev_lat, 1'b0);
         chk("load_when_full", (uart_tx_empty === 1'b1), uart_tx_empty, 1'b1);
      end else begin
         chk("idle_data", (dat === 8'h00), dat, 8'h00);
      end
      chk("pop_onehot", ($onehot0(pop) === 1'b1), $onehot0(pop), 1'b1);
      if (pop != 0) begin
         chk("pop_with_latch", (lat === 1'b1), lat, 1'b1);
         chk("pop_granted", (pop === (NCH'(1) << grant_ch)), pop, (NCH'(1) << grant_ch));
         chk("pop_valid", ((pop & ~ch_valid) === {NCH{1'b0}}), (pop & ~ch_valid), {NCH{1'b0}});
         n_pops++;
      end
      if (truncated) n_trunc++;
      if (lat) n_lat++;
      prev_lat = lat;
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++)
         if (pop[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
      ch_req = '0;
      if (rand_empty) uart_tx_empty = ($urandom_range(0, 3) != 0);
      drive_fifo();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy_s) && n < budget) begin
         tick();
         n++;
      end
      chk("idle_timeout", ((n < budget) === 1'b1), (n < budget), 1'b1);
   endtask

   task automatic wait_lat(input int cnt, input int budget);
      int n = 0;
      int l0 = n_lat;
      while ((n_lat - l0) < cnt && n < budget) begin
         tick();
         n++;
      end
      chk("latch_timeout", ((n < budget) === 1'b1), (n < budget), 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      m_rr = 0;
      prev_lat = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_latch"}, (uart_tx_latch === 1'b0), uart_tx_latch, 1'b0);
      chk({tag, "_data"}, (uart_tx_data === 8'h00), uart_tx_data, 8'h00);
      chk({tag, "_pop"}, (ch_pop === {NCH{1'b0}}), ch_pop, {NCH{1'b0}});
      chk({tag, "_busy"}, (busy === 1'b0), busy, 1'b0);
      chk({tag, "_grant"}, (grant_ch === {CW{1'b0}}), grant_ch, {CW{1'b0}});
      chk({tag, "_trunc"}, (truncated === 1'b0), truncated, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, t0, l0;
      logic [NCH-1:0] mask;
      reset = 1'b0;
      ch_req = '0;
      uart_tx_empty = 1'b1;
      drive_fifo();

      // Reset state
      tick();
      tick();
      check_reset_outputs("reset");
      reset = 1'b1;

      // Single packet with fixed expected characters
      fifo[0].push_back(8'h3C);
      fifo[0].push_back(8'hA5);
      drive_fifo();
      exp_q = '{8'h62, 8'h33, 8'h43, 8'h41, 8'h35};
      push_eol();
      p0 = n_pops;
      ch_req = 3'b001;
      tick();
      wait_idle(100);
      chk("t1_pops", ((n_pops - p0) === 2), n_pops - p0, 2);
      chk("t1_busy_after_eol", (busy === 1'b0), busy, 1'b0);
      chk("t1_grant", (grant_ch === 2'd0), grant_ch, 2'd0);
      exp_pops += 2;

      // Simultaneous requests from rr_ptr=0, then a rotated triple
      do_reset();
      push(0, 8'h01);
      push(1, 8'h01);
      model_grant(3'b011);
      ch_req = 3'b011;
      tick();
      wait_idle(200);
      chk("t2_grant", (grant_ch === CW'(m_last)), grant_ch, CW'(m_last));
      push(0, 8'h01);
      push(1, 8'h01);
      push(2, 8'hF0);
      model_grant(3'b111);
      ch_req = 3'b111;
      tick();
      wait_idle(200);
      chk("t2b_grant", (grant_ch === CW'(m_last)), grant_ch, CW'(m_last));

      // Length cap: three bytes, two sent, remainder on the next grant
      t0 = n_trunc;
      push(2, 8'h9B);
      push(2, 8'h4E);
      push(2, 8'hD7);
      model_grant(3'b100);
      ch_req = 3'b100;
      tick();
      wait_idle(200);
      chk("t3_trunc", ((n_trunc - t0) === 1), n_trunc - t0, 1);
      chk("t3_left", (fifo[2].size() === 1), fifo[2].size(), 1);
      t0 = n_trunc;
      model_grant(3'b100);
      ch_req = 3'b100;
      tick();
      wait_idle(200);
      chk("t3b_trunc", ((n_trunc - t0) === 0), n_trunc - t0, 0);
      chk("t3b_left", (fifo[2].size() === 0), fifo[2].size(), 0);

      // Re-request while the same channel is being served
      push(1, 8'h5E);
      model_grant(3'b010);
      ch_req = 3'b010;
      tick();
      begin
         int n = 0;
         while (!busy_s && n < 20) begin tick(); n++; end
         chk("t4_busy_timeout", ((n < 20) === 1'b1), (n < 20), 1'b1);
      end
      model_grant(3'b010);
      ch_req = 3'b010;
      tick();
      wait_idle(200);
      chk("t4_grant", (grant_ch === 2'd1), grant_ch, 2'd1);

      // UART stall mid-data
      push(0, 8'h7A);
      push(0, 8'hC4);
      model_grant(3'b001);
      ch_req = 3'b001;
      tick();
      wait_lat(3, 50);
      uart_tx_empty = 1'b0;
      l0 = n_lat;
      p0 = n_pops;
      repeat (20) tick();
      chk("t5_stall_latch", ((n_lat - l0) === 0), n_lat - l0, 0);
      chk("t5_stall_pop", ((n_pops - p0) === 0), n_pops - p0, 0);
      uart_tx_empty = 1'b1;
      wait_idle(200);

      // Randomized rounds with random UART readiness
      rand_empty = 1'b1;
      for (int r = 0; r < 30; r++) begin
         for (int c = 0; c < NCH; c++) begin
            int nb;
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) push(c, 8'($urandom));
         end
         mask = NCH'($urandom_range(1, (1 << NCH) - 1));
         model_grant(mask);
         ch_req = mask;
         tick();
         wait_idle(800);
         chk("rand_grant", (grant_ch === CW'(m_last)), grant_ch, CW'(m_last));
      end
      rand_empty = 1'b0;
      uart_tx_empty = 1'b1;
      chk("total_trunc", (n_trunc === exp_trunc), n_trunc, exp_trunc);
      chk("total_pops", (n_pops === exp_pops), n_pops, exp_pops);
      for (int c = 0; c < NCH; c++)
         chk("fifo_level", (fifo[c].size() === mq[c].size()), fifo[c].size(), mq[c].size());

      // Reset mid-packet drops the packet and queued requests
      push(0, 8'h12);
      push(0, 8'h34);
      push(1, 8'h56);
      model_grant(3'b011);
      ch_req = 3'b011;
      tick();
      wait_lat(2, 50);
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      tick();
      reset = 1'b1;
      exp_q.delete();
      for (int c = 0; c < NCH; c++) mq[c] = fifo[c];
      m_rr = 0;
      prev_lat = 1'b0;
      l0 = n_lat;
      repeat (10) tick();
      chk("midreset_quiet_busy", (busy_s === 1'b0), busy_s, 1'b0);
      chk("midreset_quiet_latch", ((n_lat - l0) === 0), n_lat - l0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
